gate_checker: RTL
=================

# gate_checker

Self-checking response monitor for the gate-level simulation benches. The bench drives a gate, then issues a check request to this block with the applied inputs and the selected gate function. The block waits a configurable settle time for the gate's propagation delay, samples the gate output, and compares it with the computed expected value. It keeps saturating pass and fail counters, so benches report results without manual waveform inspection.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: clock cycles to wait between capture and sample. Legal range 0..15.
- `CNT_W`, default 8: width of the pass and fail counters.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  check request; sampled only in IDLE.
- `op`  in  2  gate function under test, captured on accepted `start`.
- `a_in`  in  1  stimulus input A, captured on accepted `start`.
- `b_in`  in  1  stimulus input B, captured on accepted `start`.
- `s_obs`  in  1  observed gate output.
- `clear`  in  1  synchronous clear of both counters.
- `busy`  out  1  high from the cycle after accept until `done`, inclusive.
- `done`  out  1  one-cycle pulse when a comparison completes.
- `pass`  out  1  comparison result; valid while `done` is high, holds its value until the next `done`.
- `expected`  out  1  expected output for the captured request.
- `pass_cnt`  out  CNT_W  number of passing checks, saturating.
- `fail_cnt`  out  CNT_W  number of failing checks, saturating.

## Operation
- `op` encoding: 00 AND, 01 OR, 10 XOR, 11 NAND.
- FSM states and transitions:
  - IDLE: on `start`=1, capture `op`, `a_in`, `b_in` and compute `expected`. Go to WAIT if `SETTLE_CYCLES`>0, otherwise go to SAMPLE.
  - WAIT: a down-counter is loaded with `SETTLE_CYCLES` on accept. Leave for SAMPLE on the cycle the counter reaches 1.
  - SAMPLE: compare `s_obs` with `expected`. Set `pass` = (`s_obs`==`expected`). Increment exactly one counter. Assert `done`. Return to IDLE.
- `start` is ignored while not in IDLE; no queuing.
- `s_obs` is sampled only in SAMPLE; changes during WAIT are ignored.
- Counters saturate at 2^CNT_W-1 and never wrap.
- `clear` zeroes both counters in any state. If `clear` coincides with a SAMPLE increment, `clear` wins and both counters end at 0. `clear` does not affect the FSM, `pass` or `expected`.
- X or Z on `s_obs` in simulation compares as mismatch and counts as a fail.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `expected`=0, `pass_cnt`=0, `fail_cnt`=0; FSM in IDLE.
- Reset asserted mid-operation aborts immediately: no `done` pulse and no counter update. After `rst_n` rises, the first `start` is recognised at the next rising edge.
- Latency: `start` accepted at edge E0 gives `done` high for the cycle following edge E0+SETTLE_CYCLES+1.
  - `SETTLE_CYCLES`=0 gives `done` after E0+1.
- `s_obs` is sampled at edge E0+SETTLE_CYCLES+1.
- `busy` is high from E0 up to and including the `done` cycle.
- A new `start` is accepted at the earliest on the edge after `done` falls back to IDLE, giving a back-to-back throughput of one check per SETTLE_CYCLES+2 cycles.
- Counters update at the same edge that asserts `done`.

## Structure
- Shared package `gate_pkg`:
  - `op` encoding constants: `OP_AND`, `OP_OR`, `OP_XOR`, `OP_NAND`.
  - FSM state typedef: IDLE, WAIT, SAMPLE.
  - function `gate_eval(op, a, b)`, reused by future gate benches.
- One sub-module, `settle_timer`: a loadable down-counter with a `load` input and an `expired` output. Its width is sized from `SETTLE_CYCLES`.
- Counters and FSM live in `gate_checker`.

## Test plan
All scenarios use `SETTLE_CYCLES`=2 and `CNT_W`=8 unless stated.
- AND, a=1, b=0, `s_obs`=0 → `done` for the cycle after E0+3, `pass`=1, `expected`=0, `pass_cnt`=1, `fail_cnt`=0.
- AND, a=1, b=1, `s_obs` stuck at 0 → `pass`=0, `expected`=1, `fail_cnt`=1, `pass_cnt` unchanged.
- `start` pulsed again at E0+1 and E0+2 during WAIT → exactly one `done`, and only one counter increments by 1.
- `CNT_W`=2, five passing XOR checks (a=1, b=0, `s_obs`=1) → `pass_cnt` reads 1, 2, 3, 3, 3; `fail_cnt`=0.
- `rst_n` dropped at E0+1 and released at E0+4 → no `done` and all outputs 0. A subsequent NAND check with a=0, b=0, `s_obs`=1 passes with `pass_cnt`=1.
- `clear` asserted on the SAMPLE edge of a passing check → `pass_cnt`=0, `fail_cnt`=0, `done`=1, `pass`=1.

Source files
------------

// File: rtl/gate_checker_pkg.sv
// Shared definitions for the gate-level response checkers: op encoding,
// checker FSM states and the reference gate model.
package gate_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    SAMPLE = 2'b10
  } state_t;

  function automatic logic gate_eval(input logic [1:0] op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_checker_settle_timer.sv
// Loadable down-counter that flags the last settle cycle before sampling.
module settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);

  localparam int W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  logic [W-1:0] cnt_q;

  // Stops at zero so an idle timer never raises expired spuriously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= W'(SETTLE_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired = (cnt_q == W'(1));

endmodule

// File: rtl/gate_checker.sv
// Gate response checker: captures a request, waits for the gate to settle,
// compares the observed output and keeps saturating pass/fail counters.
module gate_checker
  import gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             s_obs,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             expected,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  logic             busy_q, done_q, pass_q, expected_q;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             accept, sample_now, pass_now, expired;

  assign accept     = (state_q == IDLE) && start;
  assign sample_now = (state_q == SAMPLE);
  // Case equality so an unknown observed value counts as a mismatch.
  assign pass_now   = (s_obs === expected_q);

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      expected_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= start;
          if (start) begin
            expected_q <= gate_eval(op, a_in, b_in);
            state_q    <= (SETTLE_CYCLES > 0) ? WAIT : SAMPLE;
          end
        end
        WAIT: begin
          if (expired) state_q <= SAMPLE;
        end
        SAMPLE: begin
          // busy stays high through the done cycle; IDLE drops it next edge.
          pass_q  <= pass_now;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (clear) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end else if (sample_now) begin
      if (pass_now) begin
        if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_W'(1);
      end else begin
        if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign expected = expected_q;
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;

endmodule
